// File: rtl/square_analyzer_if.sv
// Bus for square_analyzer: measured input and enable in, measurement results out.
interface square_analyzer_if #(
    parameter int unsigned CNT_W = 20
);
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [6:0]       duty_pct;
    logic [1:0]       duty_mode;
    logic             mode_match;
    logic             meas_valid;
    logic             timeout;
    logic             overrun;

    // Driver / consumer side
    modport master (
        output sig_in, enable,
        input  period, high_time, duty_pct, duty_mode, mode_match, meas_valid, timeout, overrun
    );

    // Analyzer side
    modport slave (
        input  sig_in, enable,
        output period, high_time, duty_pct, duty_mode, mode_match, meas_valid, timeout, overrun
    );
endinterface

// File: rtl/square_analyzer.sv
// Square-wave analyzer: measures period and high time of an asynchronous input,
// derives duty cycle with a 7-step restoring divider and classifies it against
// the fixed duty classes 1/2, 1/3, 1/4 and 1/7.
module square_analyzer #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    square_analyzer_if.slave bus
);
    localparam int unsigned NUM_W = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   sync_level;
    logic                   rise_det;
    logic                   fall_det;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] high_lat_q;
    logic             en_q;

    // Divider working state
    logic             div_busy_q;
    logic             div_fin_q;
    logic [2:0]       step_q;
    logic [NUM_W-1:0] rem_q;
    logic [NUM_W-1:0] dsh_q;
    logic [6:0]       quot_q;
    logic [CNT_W-1:0] per_r_q;
    logic [CNT_W-1:0] high_r_q;
    logic             stale_q;

    logic [6:0] res_pct;
    logic [1:0] res_mode;
    logic       res_match;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign rise_det   = sync_level & ~sync_prev_q;
    assign fall_det   = ~sync_level & sync_prev_q;

    // Synchronizer chain plus delayed copy of the last stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            sync_prev_q <= sync_level;
        end
    end

    // Duty class: nearest of the centres 50/33/25/14 (tie at 29 goes to 1/3)
    always_comb begin
        res_pct   = stale_q ? 7'd100 : quot_q;
        res_mode  = 2'b11;
        if (res_pct >= 7'd42) begin
            res_mode = 2'b00;
        end else if (res_pct >= 7'd29) begin
            res_mode = 2'b01;
        end else if (res_pct >= 7'd20) begin
            res_mode = 2'b10;
        end
        res_match = (res_pct >= 7'd48 && res_pct <= 7'd52) ||
                    (res_pct >= 7'd31 && res_pct <= 7'd35) ||
                    (res_pct >= 7'd23 && res_pct <= 7'd27) ||
                    (res_pct >= 7'd12 && res_pct <= 7'd16);
    end

    // Measurement FSM, counter, divider and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            high_lat_q     <= '0;
            en_q           <= 1'b0;
            div_busy_q     <= 1'b0;
            div_fin_q      <= 1'b0;
            step_q         <= '0;
            rem_q          <= '0;
            dsh_q          <= '0;
            quot_q         <= '0;
            per_r_q        <= '0;
            high_r_q       <= '0;
            stale_q        <= 1'b0;
            bus.period     <= '0;
            bus.high_time  <= '0;
            bus.duty_pct   <= '0;
            bus.duty_mode  <= '0;
            bus.mode_match <= 1'b0;
            bus.meas_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            en_q           <= bus.enable;
            bus.meas_valid <= 1'b0;
            if (bus.enable && !en_q) begin
                bus.overrun <= 1'b0;
            end
            if (!bus.enable) begin
                // Abort any division; results and flags hold
                state_q    <= StIdle;
                div_busy_q <= 1'b0;
                div_fin_q  <= 1'b0;
            end else begin
                // One quotient bit per cycle, MSB first
                if (div_busy_q) begin
                    if (rem_q >= dsh_q) begin
                        rem_q  <= rem_q - dsh_q;
                        quot_q <= {quot_q[5:0], 1'b1};
                    end else begin
                        quot_q <= {quot_q[5:0], 1'b0};
                    end
                    dsh_q  <= dsh_q >> 1;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd6) begin
                        div_busy_q <= 1'b0;
                        div_fin_q  <= 1'b1;
                    end
                end
                if (div_fin_q) begin
                    div_fin_q      <= 1'b0;
                    bus.period     <= per_r_q;
                    bus.high_time  <= high_r_q;
                    bus.duty_pct   <= res_pct;
                    bus.duty_mode  <= res_mode;
                    bus.mode_match <= res_match;
                    bus.meas_valid <= 1'b1;
                    bus.timeout    <= 1'b0;
                end
                unique case (state_q)
                    StIdle: state_q <= StArm;
                    StArm: begin
                        if (rise_det) begin
                            state_q <= StMeasure;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    StMeasure: begin
                        if (rise_det) begin
                            cnt_q <= CNT_W'(1);
                            if (div_busy_q) begin
                                bus.overrun <= 1'b1;
                            end else begin
                                div_busy_q <= 1'b1;
                                step_q     <= '0;
                                quot_q     <= '0;
                                rem_q      <= NUM_W'(high_lat_q) * NUM_W'(100);
                                dsh_q      <= NUM_W'(cnt_q) << 6;
                                per_r_q    <= cnt_q;
                                high_r_q   <= high_lat_q;
                                stale_q    <= (high_lat_q > cnt_q);
                            end
                        end else if (cnt_q == CNT_MAX) begin
                            // Counter saturated: report a timeout and re-arm
                            bus.timeout    <= 1'b1;
                            bus.period     <= '0;
                            bus.high_time  <= '0;
                            bus.duty_pct   <= sync_level ? 7'd100 : 7'd0;
                            bus.meas_valid <= 1'b1;
                            state_q        <= StArm;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (fall_det) begin
                            high_lat_q <= cnt_q;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: doc/square_analyzer.md
SQUARE_ANALYZER -- requirements
Module: square_analyzer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 20, giving the width of the period and high-time counters.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops (minimum 2).
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sig_in  input  1  asynchronous pulse/square input under measurement.
REQ-006 enable  input  1  measurement enable; level-sensitive.
REQ-007 period  output  CNT_W  last measured period, in clk cycles.
REQ-008 high_time  output  CNT_W  last measured high time, in clk cycles.
REQ-009 duty_pct  output  7  duty cycle, floor(high_time*100/period), range 0..100.
REQ-010 duty_mode  output  2  nearest fixed duty class: 00=1/2, 01=1/3, 10=1/4, 11=1/7.
REQ-011 mode_match  output  1  duty_pct lies inside the tolerance window of duty_mode.
REQ-012 meas_valid  output  1  one-cycle pulse: all result outputs were updated this cycle.
REQ-013 timeout  output  1  no rising edge seen for 2^CNT_W-1 cycles.
REQ-014 overrun  output  1  sticky flag: a completed period was dropped because the divider was busy.

Function
REQ-015 sig_in SHALL pass through SYNC_STAGES flops; edge detection SHALL compare the last synchronizer stage against a one-cycle-delayed copy.
REQ-016 A rising edge sampled at clk edge k SHALL be detected (rise_det) at edge k+SYNC_STAGES; falling edges (fall_det) follow the same timing.
REQ-017 Measurement FSM states SHALL be IDLE, ARM and MEASURE.
  - IDLE -> ARM when enable=1.
  - ARM -> MEASURE on rise_det.
  - MEASURE -> MEASURE on each rise_det.
  - any state -> IDLE when enable=0.
REQ-018 Counter rule: at a rise_det, cnt SHALL load 1; in MEASURE without a rise_det, cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-019 In MEASURE, fall_det SHALL latch high_lat <= cnt.
REQ-020 On rise_det in MEASURE, the block SHALL capture period_c=cnt and high_c=high_lat, and start the divider if it is idle.
REQ-021 If the divider is busy at that capture, the capture SHALL be discarded and overrun SHALL be set.
REQ-022 The divider SHALL be a sequential restoring divider computing floor(high_c*100/period_c) with 7 quotient bits.
  - Busy cycles: C+1..C+7, where C is the capture cycle.
  - At C+8, period, high_time, duty_pct, duty_mode and mode_match SHALL update and meas_valid SHALL pulse.
REQ-023 If high_c > period_c (no falling edge this period, so high_lat is stale), duty_pct SHALL be forced to 100.
REQ-024 duty_mode/mode_match windows (inclusive):
  - 48..52 gives 00.
  - 31..35 gives 01.
  - 23..27 gives 10.
  - 12..16 gives 11.
  - Outside every window: mode_match=0 and duty_mode holds the nearest class by absolute distance; ties go to the lower code.
REQ-025 Timeout: when cnt saturates in MEASURE, the block SHALL do all of the following in that cycle and then return to ARM:
  - set timeout=1 and period=0, high_time=0;
  - set duty_pct=100 if the synchronized level is 1, else 0;
  - pulse meas_valid.
REQ-026 timeout SHALL clear at the next meas_valid produced by a normal measurement.
REQ-027 enable deassertion SHALL abort any in-progress division without a meas_valid, and SHALL hold all result outputs and flags.
REQ-028 overrun SHALL clear only on reset or on the rising edge of enable.
REQ-029 Simultaneous rise_det and saturation SHALL be treated as rise_det; no timeout SHALL be raised.

Reset
REQ-030 While rst=1, the following SHALL be 0: FSM=IDLE, synchronizer flops, cnt, high_lat, divider state, period, high_time, duty_pct, duty_mode, mode_match, meas_valid, timeout and overrun.
REQ-031 Reset asserted mid-division SHALL suppress that result; the first measurement after reset release SHALL require two rise_det events.

Verification
REQ-032 enable=1, sig_in period 10 clk, high 5 -> from the second complete period: period=10, high_time=5, duty_pct=50, duty_mode=00, mode_match=1; meas_valid 8 cycles after each capture.
REQ-033 Period 700, high 100 -> duty_pct=14, duty_mode=11, mode_match=1; period 100, high 99 -> duty_pct=99, duty_mode=00, mode_match=0.
REQ-034 Period 4, high 2 -> captures land while the divider is busy, so overrun=1, and no meas_valid closer than 8 cycles apart.
REQ-035 sig_in held high after a valid period with CNT_W=8 -> 255 cycles after the last rise: timeout=1, duty_pct=100, period=0; the next two rising edges clear timeout.
REQ-036 rst pulsed 3 cycles after a capture -> no meas_valid, all outputs 0; after release, outputs stay 0 until two rise_det events plus 8 cycles.
